// File: rtl/fft_pingpong_sched.sv
// -----------------------------------------------------------------------------
// fft_pingpong_sched
//
// Top-level sequencer for the ping-pong FFT dataflow. Launches NUM_STAGES
// butterfly engines strictly one at a time, in order, using each engine's
// ap_start/ap_ready/ap_done/ap_continue handshake. Tracks which of the two
// buffer banks the active stage reads (it writes the other one), reports the
// bank holding the final result, and aborts the frame if a stage hangs.
//
// Ports
//   ap_clk, ap_rst_n     clock (rising edge), async active-low reset
//   ap_start/ap_ready    frame request / request accepted (combinational pulse)
//   ap_done/ap_continue  frame finished (held) / consumer took the result
//   ap_idle              scheduler idle and not being started
//   in_bank              bank holding the input frame, sampled on accept
//   out_bank             bank holding the result, valid while ap_done=1
//   stage_start          per-stage ap_start, one-hot or zero
//   stage_ready          per-stage ap_ready (only the active bit is used)
//   stage_done           per-stage ap_done (only the active bit is used)
//   stage_continue       per-stage ap_continue, one-hot single-cycle pulse
//   rd_bank              bank read by the active stage; it writes ~rd_bank
//   cur_stage            index of the active stage
//   tmo_limit            per-stage watchdog limit in cycles, 0 disables it
//   err                  watchdog abort happened in this frame (sticky)
//   frame_cnt            completed frames, wrapping
//
// State  | meaning
// -------+---------------------------------------------------------------
// IDLE   | waiting for ap_start
// START  | stage_start[idx] asserted, waiting for the stage to accept
// WAIT   | stage accepted, waiting for its done
// ACK    | one-cycle stage_continue[idx], advance to next stage or finish
// DONE   | ap_done held until ap_continue
// -----------------------------------------------------------------------------
module fft_pingpong_sched #(
    parameter int NUM_STAGES = 10,
    parameter int IDX_W      = 4,
    parameter int TMO_W      = 16
) (
    input  logic                  ap_clk,
    input  logic                  ap_rst_n,
    input  logic                  ap_start,
    output logic                  ap_ready,
    output logic                  ap_done,
    input  logic                  ap_continue,
    output logic                  ap_idle,
    input  logic                  in_bank,
    output logic                  out_bank,
    output logic [NUM_STAGES-1:0] stage_start,
    input  logic [NUM_STAGES-1:0] stage_ready,
    input  logic [NUM_STAGES-1:0] stage_done,
    output logic [NUM_STAGES-1:0] stage_continue,
    output logic                  rd_bank,
    output logic [IDX_W-1:0]      cur_stage,
    input  logic [TMO_W-1:0]      tmo_limit,
    output logic                  err,
    output logic [15:0]           frame_cnt
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_WAIT,
        S_ACK,
        S_DONE
    } state_t;

    // An odd stage count leaves the result in the bank opposite the input.
    localparam logic ODD_STAGES = 1'((NUM_STAGES % 2) != 0);

    state_t                  state;
    logic [IDX_W-1:0]        idx;
    logic [TMO_W-1:0]        tmo;
    logic                    bank_q;
    logic                    err_q;
    logic [15:0]             frame_q;

    logic [NUM_STAGES-1:0]   idx_oh;
    logic                    sel_ready;
    logic                    sel_done;
    logic                    last_stage;
    logic                    tmo_hit;
    logic [TMO_W-1:0]        tmo_next;

    always_comb begin
        idx_oh = '0;
        for (int i = 0; i < NUM_STAGES; i++) begin
            idx_oh[i] = (idx == IDX_W'(i));
        end
    end

    // Handshake bits of stages other than the active one are masked off here.
    assign sel_ready  = |(stage_ready & idx_oh);
    assign sel_done   = |(stage_done & idx_oh);
    assign last_stage = (idx == IDX_W'(NUM_STAGES - 1));
    assign tmo_hit    = (tmo_limit != '0) && (tmo == tmo_limit - 1'b1);
    // Saturate so a disabled or very long watchdog never wraps into a false hit.
    assign tmo_next   = (tmo == '1) ? tmo : tmo + 1'b1;

    // Outputs decode the state registers directly, so every handshake output
    // drops as soon as the async reset forces IDLE. ap_ready is also gated by
    // the reset pin so an ap_start held during reset is never acknowledged.
    assign ap_ready       = (state == S_IDLE) && ap_start && ap_rst_n;
    assign ap_idle        = (state == S_IDLE) && !ap_start;
    assign ap_done        = (state == S_DONE);
    assign stage_start    = (state == S_START) ? idx_oh : '0;
    assign stage_continue = (state == S_ACK) ? idx_oh : '0;
    assign rd_bank        = bank_q ^ idx[0];
    assign out_bank       = bank_q ^ ODD_STAGES;
    assign cur_stage      = idx;
    assign err            = err_q;
    assign frame_cnt      = frame_q;

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            state   <= S_IDLE;
            idx     <= '0;
            tmo     <= '0;
            bank_q  <= 1'b0;
            err_q   <= 1'b0;
            frame_q <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (ap_start) begin
                        bank_q <= in_bank;
                        idx    <= '0;
                        tmo    <= '0;
                        err_q  <= 1'b0;
                        state  <= S_START;
                    end
                end
                S_START: begin
                    tmo <= tmo_next;
                    // A stage finishing on the watchdog cycle takes priority.
                    if (sel_ready && sel_done) begin
                        state <= S_ACK;
                    end else if (tmo_hit) begin
                        err_q <= 1'b1;
                        state <= S_DONE;
                    end else if (sel_ready) begin
                        state <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    tmo <= tmo_next;
                    if (sel_done) begin
                        state <= S_ACK;
                    end else if (tmo_hit) begin
                        err_q <= 1'b1;
                        state <= S_DONE;
                    end
                end
                S_ACK: begin
                    tmo <= '0;
                    if (last_stage) begin
                        state <= S_DONE;
                    end else begin
                        idx   <= idx + 1'b1;
                        state <= S_START;
                    end
                end
                S_DONE: begin
                    if (ap_continue) begin
                        frame_q <= frame_q + 1'b1;
                        state   <= S_IDLE;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fft_pingpong_sched.sv
// -----------------------------------------------------------------------------
// Directed bench for fft_pingpong_sched. Two instances: a 10-stage one (a_*)
// and a 3-stage one (b_*). Each has a behavioural stage model: ready on
// launch, done either in the launch cycle (zero-latency) or a fixed number of
// cycles later, with an optional hung stage and injectable stray done bits.
// -----------------------------------------------------------------------------
module tb_fft_pingpong_sched;

    logic ap_clk = 1'b0;
    logic ap_rst_n;
    always #5 ap_clk = ~ap_clk;

    int n_chk  = 0;
    int n_fail = 0;

    // 10-stage instance
    logic        a_start, a_ready, a_done, a_cont, a_idle, a_inb, a_outb, a_rd, a_err;
    logic [9:0]  a_ss, a_sr, a_sd, a_sc;
    logic [3:0]  a_cur;
    logic [15:0] a_tmo, a_fc;
    // 3-stage instance
    logic        b_start, b_ready, b_done, b_cont, b_idle, b_inb, b_outb, b_rd, b_err;
    logic [2:0]  b_ss, b_sr, b_sd, b_sc;
    logic [1:0]  b_cur;
    logic [15:0] b_tmo, b_fc;

    fft_pingpong_sched dut_a (
        .ap_clk(ap_clk), .ap_rst_n(ap_rst_n),
        .ap_start(a_start), .ap_ready(a_ready), .ap_done(a_done),
        .ap_continue(a_cont), .ap_idle(a_idle),
        .in_bank(a_inb), .out_bank(a_outb),
        .stage_start(a_ss), .stage_ready(a_sr), .stage_done(a_sd),
        .stage_continue(a_sc), .rd_bank(a_rd), .cur_stage(a_cur),
        .tmo_limit(a_tmo), .err(a_err), .frame_cnt(a_fc)
    );

    fft_pingpong_sched #(.NUM_STAGES(3), .IDX_W(2), .TMO_W(16)) dut_b (
        .ap_clk(ap_clk), .ap_rst_n(ap_rst_n),
        .ap_start(b_start), .ap_ready(b_ready), .ap_done(b_done),
        .ap_continue(b_cont), .ap_idle(b_idle),
        .in_bank(b_inb), .out_bank(b_outb),
        .stage_start(b_ss), .stage_ready(b_sr), .stage_done(b_sd),
        .stage_continue(b_sc), .rd_bank(b_rd), .cur_stage(b_cur),
        .tmo_limit(b_tmo), .err(b_err), .frame_cnt(b_fc)
    );

    function automatic int oh_idx(input logic [31:0] v);
        for (int i = 0; i < 32; i++) begin
            if (v[i]) return i;
        end
        return 0;
    endfunction

    // Stage model, 10-stage instance
    logic       a_zero;
    int         a_dly, a_hang;
    logic [9:0] a_inj;
    logic       a_busy;
    int         a_bst, a_bcnt;

    always @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            a_busy <= 1'b0;
        end else if (|a_sc) begin
            a_busy <= 1'b0;
        end else if (|a_ss) begin
            a_busy <= 1'b1;
            a_bst  <= oh_idx(32'(a_ss));
            a_bcnt <= 1;
        end else if (a_busy) begin
            a_bcnt <= a_bcnt + 1;
        end
    end

    assign a_sr = a_ss;
    always_comb begin
        a_sd = a_inj;
        if (a_zero) a_sd = a_sd | a_ss;
        else if (a_busy && a_bcnt >= a_dly && a_bst != a_hang) a_sd = a_sd | (10'd1 << a_bst);
    end

    // Stage model, 3-stage instance (always delayed-done)
    int         b_dly;
    logic       b_busy;
    int         b_bst, b_bcnt;

    always @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            b_busy <= 1'b0;
        end else if (|b_sc) begin
            b_busy <= 1'b0;
        end else if (|b_ss) begin
            b_busy <= 1'b1;
            b_bst  <= oh_idx(32'(b_ss));
            b_bcnt <= 1;
        end else if (b_busy) begin
            b_bcnt <= b_bcnt + 1;
        end
    end

    assign b_sr = b_ss;
    always_comb begin
        b_sd = '0;
        if (b_busy && b_bcnt >= b_dly) b_sd = 3'd1 << b_bst;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge ap_clk);
        #1;
    endtask

    logic [9:0] ss_ok, sc_ok, rd_seq;
    logic       c1_seen, bad;

    initial begin
        #200000;
        $display("FAIL watchdog: bench time limit reached");
        $fatal(1, "bench time limit");
    end

    initial begin
        a_start = 0; a_cont = 0; a_inb = 0; a_tmo = 0;
        a_zero = 0; a_dly = 5; a_hang = -1; a_inj = '0;
        b_start = 0; b_cont = 0; b_inb = 0; b_tmo = 0; b_dly = 5;
        ap_rst_n = 0;
        #23 ap_rst_n = 1;
        tick();

        // Reset state
        #1;
        chk("rst_idle",  32'(a_idle), 1);
        chk("rst_done",  32'(a_done), 0);
        chk("rst_ready", 32'(a_ready), 0);
        chk("rst_ss",    32'(a_ss), 0);
        chk("rst_err",   32'(a_err), 0);
        chk("rst_fc",    32'(a_fc), 0);
        chk("rst_cur",   32'(a_cur), 0);
        chk("rst_b_idle", 32'(b_idle), 1);
        tick();

        // 3 stages, done 5 cycles after launch
        for (int c = 0; c <= 23; c++) begin
            b_start = (c == 0);
            b_cont  = (c == 22);
            #1;
            if (c == 0) begin
                chk("t1_ready", 32'(b_ready), 1);
                chk("t1_idle",  32'(b_idle), 0);
            end
            if (c == 1) begin
                chk("t1_ss0", 32'(b_ss), 1);
                chk("t1_rd0", 32'(b_rd), 0);
            end
            if (c == 7)  chk("t1_sc0", 32'(b_sc), 1);
            if (c == 14) begin
                chk("t1_sc1", 32'(b_sc), 2);
                chk("t1_rd1", 32'(b_rd), 1);
            end
            if (c == 21) begin
                chk("t1_sc2",    32'(b_sc), 4);
                chk("t1_done_e", 32'(b_done), 0);
            end
            if (c == 22) begin
                chk("t1_done", 32'(b_done), 1);
                chk("t1_outb", 32'(b_outb), 1);
                chk("t1_err",  32'(b_err), 0);
            end
            if (c == 23) begin
                chk("t1_idle2", 32'(b_idle), 1);
                chk("t1_fc",    32'(b_fc), 1);
            end
            tick();
        end

        // 10 stages, zero latency, in_bank=1
        a_zero = 1; a_inb = 1;
        ss_ok = '0; sc_ok = '0; rd_seq = '0;
        for (int c = 0; c <= 22; c++) begin
            a_start = (c == 0);
            a_cont  = (c == 21);
            #1;
            if (c == 0) chk("t2_ready", 32'(a_ready), 1);
            if (c >= 1 && c <= 19 && (c % 2) == 1) begin
                ss_ok[(c - 1) / 2]  = (a_ss === (10'd1 << ((c - 1) / 2))) && (a_cur === 4'((c - 1) / 2));
                rd_seq[(c - 1) / 2] = a_rd;
            end
            if (c >= 2 && c <= 20 && (c % 2) == 0)
                sc_ok[(c - 2) / 2] = (a_sc === (10'd1 << ((c - 2) / 2)));
            if (c == 20) chk("t2_done_e", 32'(a_done), 0);
            if (c == 21) begin
                chk("t2_done", 32'(a_done), 1);
                chk("t2_outb", 32'(a_outb), 1);
            end
            if (c == 22) begin
                chk("t2_idle", 32'(a_idle), 1);
                chk("t2_fc",   32'(a_fc), 1);
            end
            tick();
        end
        chk("t2_ss_seq", 32'(ss_ok), 32'h3FF);
        chk("t2_sc_seq", 32'(sc_ok), 32'h3FF);
        chk("t2_rd_seq", 32'(rd_seq), 32'h155);

        // Watchdog: limit 8, stage 1 hangs
        a_zero = 0; a_dly = 5; a_hang = 1; a_tmo = 16'd8; a_inb = 0;
        c1_seen = 0;
        for (int c = 0; c <= 16; c++) begin
            a_start = (c == 0);
            #1;
            if (c == 8) begin
                chk("t3_ss1", 32'(a_ss), 2);
                chk("t3_cur", 32'(a_cur), 1);
            end
            if (c >= 8) c1_seen = c1_seen | a_sc[1];
            if (c == 15) chk("t3_done_e", 32'(a_done), 0);
            if (c == 16) begin
                chk("t3_done", 32'(a_done), 1);
                chk("t3_err",  32'(a_err), 1);
            end
            tick();
        end
        chk("t3_no_sc1", 32'(c1_seen), 0);

        // DONE holds against ap_start while ap_continue=0
        bad = 0;
        for (int c = 0; c < 20; c++) begin
            a_start = (c % 2 == 1);
            #1;
            bad = bad | (a_done !== 1'b1) | (a_ready !== 1'b0);
            tick();
        end
        chk("t4_hold", 32'(bad), 0);
        a_start = 0; a_cont = 1;
        #1;
        tick();
        a_cont = 0;
        #1;
        chk("t4_fc",   32'(a_fc), 2);
        chk("t4_idle", 32'(a_idle), 1);
        chk("t4_done", 32'(a_done), 0);
        chk("t4_err",  32'(a_err), 1);

        // Stray done on stage 4 while stage 2 waits; then reset mid-WAIT
        a_hang = -1; a_tmo = 0;
        for (int c = 0; c <= 24; c++) begin
            a_start = (c == 0);
            a_inj   = (c == 17) ? 10'h010 : 10'h000;
            #1;
            if (c == 0)  chk("t6_err_clr", 32'(a_err), 1);
            if (c == 17) begin
                chk("t6_cur17", 32'(a_cur), 2);
                chk("t6_sc17",  32'(a_sc), 0);
            end
            if (c == 18) begin
                chk("t6_cur18", 32'(a_cur), 2);
                chk("t6_sc18",  32'(a_sc), 0);
            end
            if (c == 21) chk("t6_sc2", 32'(a_sc), 4);
            if (c == 24) begin
                chk("t5_cur_pre", 32'(a_cur), 3);
                ap_rst_n = 0;
                a_start  = 1;
                #1;
                chk("t5_ss",    32'(a_ss), 0);
                chk("t5_done",  32'(a_done), 0);
                chk("t5_err",   32'(a_err), 0);
                chk("t5_ready", 32'(a_ready), 0);
                chk("t5_cur",   32'(a_cur), 0);
                chk("t5_fc",    32'(a_fc), 0);
                #2;
                a_start  = 0;
                ap_rst_n = 1;
            end
            tick();
        end

        // Fresh frame after reset, zero latency, in_bank=0
        a_zero = 1; a_inb = 0; a_inj = '0;
        for (int c = 0; c <= 22; c++) begin
            a_start = (c == 0);
            a_cont  = (c == 21);
            #1;
            if (c == 0) chk("t5_ready2", 32'(a_ready), 1);
            if (c == 1) begin
                chk("t5_ss0", 32'(a_ss), 1);
                chk("t5_rd0", 32'(a_rd), 0);
            end
            if (c == 21) begin
                chk("t5_done2", 32'(a_done), 1);
                chk("t5_outb",  32'(a_outb), 0);
            end
            if (c == 22) begin
                chk("t5_fc2",   32'(a_fc), 1);
                chk("t5_idle2", 32'(a_idle), 1);
            end
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
